// File: rtl/axis_wrr_sched_4_if.sv
// Handshake bundle between the weighted round-robin scheduler and its 4-input AXI-Stream mux.
// The slave modport is the scheduler; the master modport is whatever drives requests and the mux output.
interface axis_wrr_sched_4_if #(
  parameter int WEIGHT_WIDTH = 4
);
  logic [3:0]                  req;
  logic [4*WEIGHT_WIDTH-1:0]   weights;
  logic                        out_tvalid;
  logic                        out_tready;
  logic                        out_tlast;
  logic                        enable;
  logic [1:0]                  select;
  logic [3:0]                  grant;
  logic                        pkt_done;

  modport master (
    output req, weights, out_tvalid, out_tready, out_tlast,
    input  enable, select, grant, pkt_done
  );

  modport slave (
    input  req, weights, out_tvalid, out_tready, out_tlast,
    output enable, select, grant, pkt_done
  );
endinterface

// File: rtl/axis_wrr_sched_4.sv
// Packet-granular weighted round-robin scheduler for a 4-input AXI-Stream mux.
// Grants one whole packet at a time and spends one credit per packet on the granted port.
module axis_wrr_sched_4 #(
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_wrr_sched_4_if.slave    bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state, state_nxt;
  logic                    enable_q, enable_nxt;
  logic [1:0]              select_q, select_nxt;
  logic [3:0]              grant_q, grant_nxt;
  logic                    pkt_done_q, pkt_done_nxt;
  logic [1:0]              last_port, last_port_nxt;
  logic [WEIGHT_WIDTH-1:0] credit     [4];
  logic [WEIGHT_WIDTH-1:0] credit_nxt [4];

  logic [3:0]              eligible;
  logic                    pick_found;
  logic [1:0]              pick_port;
  logic [1:0]              cand;
  logic                    tlast_beat;

  assign tlast_beat = bus.out_tvalid & bus.out_tready & bus.out_tlast;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = bus.req[i] && (credit[i] != '0);
    end
  end

  // Round-robin search starts just after the port that finished the previous packet.
  always_comb begin
    pick_found = 1'b0;
    pick_port  = last_port;
    cand       = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_port + 2'(k);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_port  = cand;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    enable_nxt    = enable_q;
    select_nxt    = select_q;
    grant_nxt     = grant_q;
    pkt_done_nxt  = 1'b0;
    last_port_nxt = last_port;
    for (int i = 0; i < 4; i++) begin
      credit_nxt[i] = credit[i];
    end

    case (state)
      IDLE: begin
        if (bus.req != 4'b0000) begin
          if (!pick_found) begin
            // Requests exist but every requester is out of credit: start a new round.
            for (int i = 0; i < 4; i++) begin
              if (bus.weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0) begin
                credit_nxt[i] = WEIGHT_WIDTH'(1);
              end else begin
                credit_nxt[i] = bus.weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
              end
            end
          end else begin
            state_nxt  = ACTIVE;
            enable_nxt = 1'b1;
            select_nxt = pick_port;
            grant_nxt  = 4'b0001 << pick_port;
          end
        end
      end

      ACTIVE: begin
        if (tlast_beat) begin
          if (credit[select_q] != '0) begin
            credit_nxt[select_q] = credit[select_q] - WEIGHT_WIDTH'(1);
          end
          last_port_nxt = select_q;
          enable_nxt    = 1'b0;
          grant_nxt     = 4'b0000;
          pkt_done_nxt  = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt  = IDLE;
        enable_nxt = 1'b0;
        grant_nxt  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      enable_q   <= 1'b0;
      select_q   <= 2'd0;
      grant_q    <= 4'b0000;
      pkt_done_q <= 1'b0;
      last_port  <= 2'd3;
      for (int i = 0; i < 4; i++) begin
        credit[i] <= '0;
      end
    end else begin
      state      <= state_nxt;
      enable_q   <= enable_nxt;
      select_q   <= select_nxt;
      grant_q    <= grant_nxt;
      pkt_done_q <= pkt_done_nxt;
      last_port  <= last_port_nxt;
      for (int i = 0; i < 4; i++) begin
        credit[i] <= credit_nxt[i];
      end
    end
  end

  assign bus.enable   = enable_q;
  assign bus.select   = select_q;
  assign bus.grant    = grant_q;
  assign bus.pkt_done = pkt_done_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_grant_enable:  assert property (@(posedge clk) disable iff (!rst_n) ((grant_q != 4'b0000) == enable_q));

endmodule

// File: tb/tb_axis_wrr_sched_4.sv
// Self-checking bench for axis_wrr_sched_4: a packet-level reference model feeds a scoreboard
// that a negedge monitor drains whenever the scheduler raises enable or pulses pkt_done.
module tb_axis_wrr_sched_4;

  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  axis_wrr_sched_4_if #(.WEIGHT_WIDTH(WW)) bus ();

  axis_wrr_sched_4 #(.WEIGHT_WIDTH(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int pkt_len  = 1;
  int rdy_mode = 0;
  int beat_cnt = 0;
  bit tog      = 1'b1;

  int exp_grant_q[$];
  int exp_done_q[$];
  int sel_log[$];
  int gap_log[$];
  int done_cnt = 0;
  int cur_sel  = 0;
  bit prev_en  = 1'b0;
  int idle_cnt = 0;

  int m_credit[4];
  int m_last = 3;
  bit m_busy = 1'b0;
  int m_port = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [4*WW-1:0] w, input int len, input int mode);
    bus.req     = r;
    bus.weights = w;
    pkt_len     = len;
    rdy_mode    = mode;
  endtask

  // Reference model: one packet per grant, credits per port, round-robin from the last finisher.
  task automatic modelStep();
    int pick;
    int w;
    int p;
    if (!m_busy) begin
      if (bus.req != 4'b0000) begin
        pick = -1;
        for (int k = 1; k <= 4; k++) begin
          p = (m_last + k) % 4;
          if (pick < 0 && bus.req[p] && m_credit[p] > 0) pick = p;
        end
        if (pick < 0) begin
          for (int i = 0; i < 4; i++) begin
            w = int'(bus.weights[i*WW +: WW]);
            m_credit[i] = (w == 0) ? 1 : w;
          end
        end else begin
          m_busy = 1'b1;
          m_port = pick;
          exp_grant_q.push_back(pick);
        end
      end
    end else if (bus.out_tvalid && bus.out_tready && bus.out_tlast) begin
      m_credit[m_port] = m_credit[m_port] - 1;
      m_last = m_port;
      m_busy = 1'b0;
      exp_done_q.push_back(m_port);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0;
        m_last = 3;
        for (int i = 0; i < 4; i++) m_credit[i] = 0;
        exp_grant_q.delete();
        exp_done_q.delete();
      end else begin
        modelStep();
      end
    end
  end

  // Beat counter for the emulated mux output stream.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) beat_cnt = 0;
      else if (bus.out_tvalid && bus.out_tready) beat_cnt = bus.out_tlast ? 0 : beat_cnt + 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.enable) begin
        bus.out_tvalid = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.out_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? tog : 1'($urandom_range(0, 1));
        bus.out_tlast  = (beat_cnt == pkt_len - 1);
        tog = ~tog;
      end else begin
        bus.out_tvalid = 1'b0;
        bus.out_tready = 1'b0;
        bus.out_tlast  = 1'b0;
        tog = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en  = 1'b0;
        idle_cnt = 0;
      end else begin
        checkOutput("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        checkOutput("grant_vs_enable", 32'(bus.grant != 4'b0000), 32'(bus.enable));
        if (bus.enable && !prev_en) begin
          gap_log.push_back(idle_cnt);
          idle_cnt = 0;
          checkOutput("grant_expected", 32'(exp_grant_q.size() > 0), 32'd1);
          if (exp_grant_q.size() > 0) begin
            int e;
            e = exp_grant_q.pop_front();
            checkOutput("grant_select", 32'(bus.select), 32'(e));
            checkOutput("grant_onehot", 32'(bus.grant), 32'(1 << e));
          end
          sel_log.push_back(int'(bus.select));
          cur_sel = int'(bus.select);
        end else if (bus.enable) begin
          checkOutput("select_hold", 32'(bus.select), 32'(cur_sel));
        end
        if (!bus.enable) idle_cnt++;
        if (bus.pkt_done) begin
          done_cnt++;
          checkOutput("done_expected", 32'(exp_done_q.size() > 0), 32'd1);
          if (exp_done_q.size() > 0) checkOutput("done_port", 32'(cur_sel), 32'(exp_done_q.pop_front()));
          checkOutput("done_enable_low", 32'(bus.enable), 32'd0);
        end
        prev_en = bus.enable;
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    #1;
    checkOutput("reset_enable", 32'(bus.enable), 32'd0);
    checkOutput("reset_select", 32'(bus.select), 32'd0);
    checkOutput("reset_grant", 32'(bus.grant), 32'd0);
    checkOutput("reset_pkt_done", 32'(bus.pkt_done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitGrants(input int n, input int budget);
    int c;
    c = 0;
    while (sel_log.size() < n && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    checkOutput("wait_grants", 32'(sel_log.size() >= n), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int c;
    c = 0;
    while (bus.enable && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput("wait_idle", 32'(bus.enable), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp27[10];
    int d0;
    exp27 = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0};
    bus.out_tvalid = 1'b0;
    bus.out_tready = 1'b0;
    bus.out_tlast  = 1'b0;
    applyStimulus(4'b0000, 16'h1111, 1, 0);

    // Reload cycle then grant of port 0.
    doReset();
    applyStimulus(4'b0001, 16'h1111, 1, 0);
    @(negedge clk); #1;
    checkOutput("first_reload_enable", 32'(bus.enable), 32'd0);
    @(negedge clk); #1;
    checkOutput("first_grant_enable", 32'(bus.enable), 32'd1);
    checkOutput("first_grant_select", 32'(bus.select), 32'd0);
    checkOutput("first_grant_grant", 32'(bus.grant), 32'd1);
    bus.req = 4'b0000;
    waitIdle(20);

    // Weighted sequence with port 0 weighted 2.
    doReset();
    sel_log.delete();
    applyStimulus(4'b1111, 16'h1112, 1, 0);
    waitGrants(10, 200);
    for (int i = 0; i < 10; i++) begin
      if (i < sel_log.size()) checkOutput($sformatf("wrr_seq_%0d", i), 32'(sel_log[i]), 32'(exp27[i]));
    end
    bus.req = 4'b0000;
    waitIdle(20);

    // Stalled 4-beat packet on port 1 while port 0 requests.
    doReset();
    sel_log.delete();
    gap_log.delete();
    d0 = done_cnt;
    applyStimulus(4'b0010, 16'h1111, 4, 1);
    waitGrants(1, 20);
    bus.req = 4'b0011;
    waitGrants(2, 100);
    if (sel_log.size() >= 2) begin
      checkOutput("stall_first_port", 32'(sel_log[0]), 32'd1);
      checkOutput("stall_next_port", 32'(sel_log[1]), 32'd0);
      checkOutput("stall_gap", 32'(gap_log[1]), 32'd1);
    end
    checkOutput("stall_done_once", 32'(done_cnt - d0), 32'd1);
    bus.req = 4'b0000;
    waitIdle(50);

    // Zero weight on port 2: reload before every packet.
    doReset();
    sel_log.delete();
    gap_log.delete();
    applyStimulus(4'b0100, 16'h1011, 2, 0);
    waitGrants(3, 100);
    if (sel_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) checkOutput($sformatf("zero_w_port_%0d", i), 32'(sel_log[i]), 32'd2);
      checkOutput("zero_w_gap_1", 32'(gap_log[1]), 32'd2);
      checkOutput("zero_w_gap_2", 32'(gap_log[2]), 32'd2);
    end
    bus.req = 4'b0000;
    waitIdle(50);

    // Asynchronous reset during beat 2 of a port-3 packet.
    doReset();
    sel_log.delete();
    applyStimulus(4'b1000, 16'h1111, 4, 0);
    waitGrants(1, 20);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_enable", 32'(bus.enable), 32'd0);
    checkOutput("async_rst_grant", 32'(bus.grant), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sel_log.delete();
    bus.req = 4'b1001;
    waitGrants(1, 20);
    if (sel_log.size() >= 1) checkOutput("post_rst_port", 32'(sel_log[0]), 32'd0);
    bus.req = 4'b0000;
    waitIdle(50);

    // Randomized traffic, weights and backpressure.
    doReset();
    sel_log.delete();
    applyStimulus(4'($urandom), 16'($urandom), 1, 2);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      if ($urandom_range(0, 50) == 0) bus.weights = 16'($urandom);
      if (!bus.enable) pkt_len = int'($urandom_range(1, 3));
    end
    bus.req = 4'b0000;
    waitIdle(200);
    repeat (3) @(negedge clk);
    checkOutput("random_activity", 32'(sel_log.size() > 50), 32'd1);
    checkOutput("grant_queue_empty", 32'(exp_grant_q.size()), 32'd0);
    checkOutput("done_queue_empty", 32'(exp_done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axis_wrr_sched_4.md
AXIS_WRR_SCHED_4 -- requirements
Module: axis_wrr_sched_4

Packet-granular weighted round-robin scheduler. Drives enable/select of a 4-input AXI-Stream mux; observes the mux output handshake to detect packet end.

Interface
REQ-001 The block SHALL have parameter WEIGHT_WIDTH, default 4, giving the width of each per-port weight and credit counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: per-input tvalid; bit i is a request from input i.
REQ-005 The block SHALL have port weights, input, 4*WEIGHT_WIDTH bits: port i's weight in bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
REQ-006 The block SHALL have ports out_tvalid, out_tready and out_tlast, inputs, 1 bit each: the mux output handshake.
REQ-007 The block SHALL have port enable, output, 1 bit: mux enable, high while a packet is granted.
REQ-008 The block SHALL have port select, output, 2 bits: the granted input index.
REQ-009 The block SHALL have port grant, output, 4 bits: one-hot grant, all zero when idle.
REQ-010 The block SHALL have port pkt_done, output, 1 bit: one-cycle pulse at packet completion.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and ACTIVE; all outputs SHALL be registered.
REQ-012 The block SHALL keep a WEIGHT_WIDTH-bit credit counter per port; port i is eligible when req[i]=1 and credit[i]!=0.
REQ-013 In IDLE with req!=0 and no port eligible, the block SHALL load every credit[i] from weight i (weight 0 loads as 1), stay in IDLE, and grant nothing that cycle.
REQ-014 In IDLE with at least one eligible port, the block SHALL pick the first eligible port searching from last_port+1 upward modulo 4.
REQ-015 On that pick, at the next edge the block SHALL set enable=1, select=port, grant=onehot(port) and move to ACTIVE; latency is req sample to enable high = 1 cycle when credit is available.
REQ-016 In ACTIVE the block SHALL hold select and grant constant, ignoring req changes on every port, until a beat with out_tvalid&out_tready&out_tlast.
REQ-017 On the tlast beat, at the next edge the block SHALL decrement credit[select] by 1, set last_port=select, enable=0, grant=0 and pkt_done=1 for one cycle, and return to IDLE.
REQ-018 Packet gap: at least one IDLE cycle SHALL separate consecutive grants, so enable is low for at least one cycle between packets.
REQ-019 Weights SHALL be sampled only at credit reload; weight changes at any other time SHALL have no effect.
REQ-020 grant SHALL be $onehot0 at all times, and grant=0 exactly when enable=0.
REQ-021 A rising grant bit SHALL have had its req bit high on the prior cycle.
REQ-022 Credits SHALL never underflow; a decrement occurs only on a granted port, which had nonzero credit.
REQ-023 Beats without tlast, or with out_tvalid&out_tready low, SHALL not change state.

Reset
REQ-024 While rst_n=0 the block SHALL be in IDLE with enable=0, select=0, grant=0, pkt_done=0, all credits=0, last_port=3.
REQ-025 Reset asserted mid-packet SHALL drop enable and grant immediately (asynchronously); after release, arbitration SHALL restart from port 0 with a reload cycle first.

Verification
REQ-026 Bench: reset release, req=4'b0001 held -> reload on edge 1, enable=1 select=0 grant=0001 after edge 2.
REQ-027 Bench: weights={1,1,1,2} (ports 3..0), req=4'b1111 held, 1-beat packets with tready=1 -> first 10 selects are 0,1,2,3,0,1,2,3,0,0.
REQ-028 Bench: port 1 granted, 4-beat packet with tready toggling 1,0,1,0..., req[0]=1 throughout -> select stays 1 until the tlast beat; pkt_done pulses once; then port 0 is granted after 1 idle cycle.
REQ-029 Bench: weight 2 = 0, only req[2]=1, 3 packets -> a reload precedes every grant, and each packet is granted.
REQ-030 Bench: rst_n pulsed low during beat 2 of a port-3 packet -> enable=0 and grant=0 in the same cycle; the next grant goes to port 0 when req=4'b1001.
